// File: rtl/jtpang_bank_resp.sv
// -----------------------------------------------------------------------------
// jtpang_bank_resp
//
// Four-bank read responder for the ba_rd/ba_ack/ba_dst/ba_dok/ba_rdy bank
// request protocol. The four level-held bank requests are arbitrated
// round-robin. Each grant issues one burst read to a fixed-latency memory
// port, and BURST 16-bit words are returned on data_read with start/valid/last
// strobes.
//
// Parameters
//   BURST    words returned per grant (1..4)
//   LATENCY  cycles from mem_rd to the first valid mem_din word (1..7)
//
// Ports
//   clk                 system clock
//   rst_n               asynchronous active-low reset
//   ba0_addr..ba3_addr  per-bank 22-bit word address, sampled at grant
//   ba_rd[3:0]          per-bank read request, held until acked
//   hold                blocks new grants (sampled only while idle)
//   ba_ack[3:0]         one-hot, one-cycle grant pulse
//   ba_dst              first word of the burst on data_read
//   ba_dok              data_read valid
//   ba_rdy              last word of the burst on data_read
//   data_read[15:0]     returned word (registered copy of mem_din)
//   mem_rd              one-cycle burst read strobe
//   mem_addr[23:0]      {bank, address} of the burst
//   mem_din[15:0]       memory read data
// -----------------------------------------------------------------------------
module jtpang_bank_resp #(
    parameter int BURST   = 2,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [21:0] ba0_addr,
    input  logic [21:0] ba1_addr,
    input  logic [21:0] ba2_addr,
    input  logic [21:0] ba3_addr,
    input  logic [3:0]  ba_rd,
    input  logic        hold,
    output logic [3:0]  ba_ack,
    output logic        ba_dst,
    output logic        ba_dok,
    output logic        ba_rdy,
    output logic [15:0] data_read,
    output logic        mem_rd,
    output logic [23:0] mem_addr,
    input  logic [15:0] mem_din
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT,
        ST_DATA
    } state_t;

    localparam logic [2:0] LAT_LOAD  = 3'(LATENCY);
    localparam logic [1:0] LAST_WORD = 2'(BURST - 1);

    state_t      r_state, w_state_next;
    logic [1:0]  r_last,  w_last_next;
    logic [1:0]  r_bank,  w_bank_next;
    logic [1:0]  r_word,  w_word_next;
    logic [2:0]  r_wcnt,  w_wcnt_next;
    logic [3:0]  r_ack,   w_ack_next;
    logic        r_mem_rd, w_mem_rd_next;
    logic [23:0] r_mem_addr, w_mem_addr_next;
    logic        r_dst, w_dst_next;
    logic        r_dok, w_dok_next;
    logic        r_rdy, w_rdy_next;
    logic [15:0] r_data, w_data_next;

    logic [21:0] w_addr [4];
    logic [1:0]  w_idx  [4];
    logic [3:0]  w_rot;
    logic [1:0]  w_pick;

    assign w_addr[0] = ba0_addr;
    assign w_addr[1] = ba1_addr;
    assign w_addr[2] = ba2_addr;
    assign w_addr[3] = ba3_addr;

    // Requests rotated so that position 0 is the bank right after the last
    // winner; the lowest set position is therefore the round-robin choice.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_rot
            assign w_idx[gi] = r_last + 2'(gi + 1);
            assign w_rot[gi] = ba_rd[w_idx[gi]];
        end
    endgenerate

    always_comb begin
        w_pick = w_idx[3];
        if (w_rot[2]) w_pick = w_idx[2];
        if (w_rot[1]) w_pick = w_idx[1];
        if (w_rot[0]) w_pick = w_idx[0];
    end

    always_comb begin
        w_state_next    = r_state;
        w_last_next     = r_last;
        w_bank_next     = r_bank;
        w_word_next     = r_word;
        w_wcnt_next     = r_wcnt;
        w_mem_addr_next = r_mem_addr;
        w_data_next     = r_data;
        w_ack_next      = 4'd0;
        w_mem_rd_next   = 1'b0;
        w_dst_next      = 1'b0;
        w_dok_next      = 1'b0;
        w_rdy_next      = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (!hold && (ba_rd != 4'd0)) begin
                    w_bank_next     = w_pick;
                    w_mem_addr_next = {w_pick, w_addr[w_pick]};
                    w_ack_next      = 4'b0001 << w_pick;
                    w_mem_rd_next   = 1'b1;
                    w_state_next    = ST_GRANT;
                end
            end
            ST_GRANT: begin
                w_last_next  = r_bank;
                w_wcnt_next  = LAT_LOAD;
                w_state_next = ST_WAIT;
            end
            ST_WAIT: begin
                // Count 1 marks the cycle mem_din holds word 0; capture it so
                // it is presented as the first DATA word.
                if (r_wcnt == 3'd1) begin
                    w_data_next  = mem_din;
                    w_dst_next   = 1'b1;
                    w_dok_next   = 1'b1;
                    w_rdy_next   = (LAST_WORD == 2'd0);
                    w_word_next  = 2'd0;
                    w_state_next = ST_DATA;
                end else begin
                    w_wcnt_next = r_wcnt - 3'd1;
                end
            end
            ST_DATA: begin
                if (r_word == LAST_WORD) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_data_next = mem_din;
                    w_dok_next  = 1'b1;
                    w_rdy_next  = ((r_word + 2'd1) == LAST_WORD);
                    w_word_next = r_word + 2'd1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_last     <= 2'd3;
            r_bank     <= 2'd0;
            r_word     <= 2'd0;
            r_wcnt     <= 3'd0;
            r_ack      <= 4'd0;
            r_mem_rd   <= 1'b0;
            r_mem_addr <= 24'd0;
            r_dst      <= 1'b0;
            r_dok      <= 1'b0;
            r_rdy      <= 1'b0;
            r_data     <= 16'd0;
        end else begin
            r_state    <= w_state_next;
            r_last     <= w_last_next;
            r_bank     <= w_bank_next;
            r_word     <= w_word_next;
            r_wcnt     <= w_wcnt_next;
            r_ack      <= w_ack_next;
            r_mem_rd   <= w_mem_rd_next;
            r_mem_addr <= w_mem_addr_next;
            r_dst      <= w_dst_next;
            r_dok      <= w_dok_next;
            r_rdy      <= w_rdy_next;
            r_data     <= w_data_next;
        end
    end

    assign ba_ack    = r_ack;
    assign ba_dst    = r_dst;
    assign ba_dok    = r_dok;
    assign ba_rdy    = r_rdy;
    assign data_read = r_data;
    assign mem_rd    = r_mem_rd;
    assign mem_addr  = r_mem_addr;

endmodule

// File: tb/tb_jtpang_bank_resp.sv
// -----------------------------------------------------------------------------
// tb_jtpang_bank_resp
//
// Three responders with (BURST,LATENCY) = (2,2), (1,1), (4,7). The stimulus
// process pushes expected grants and data words into queues; a monitor
// process pops and compares whenever a DUT shows ba_ack or ba_dok, and checks
// that all outputs are zero while rst_n is low.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_jtpang_bank_resp;

    localparam int ND = 3;

    typedef struct {
        int          dut;
        int          cyc;
        logic [3:0]  ack;
        logic [23:0] addr;
    } ack_exp_t;

    typedef struct {
        int          dut;
        int          cyc;
        logic [15:0] data;
        logic        dst;
        logic        rdy;
    } dat_exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hold;
    logic [21:0] a0, a1, a2, a3;
    logic [3:0]  rd_v    [ND];
    logic [3:0]  ack_o   [ND];
    logic        dst_o   [ND];
    logic        dok_o   [ND];
    logic        rdy_o   [ND];
    logic        mrd_o   [ND];
    logic [15:0] dat_o   [ND];
    logic [23:0] maddr_o [ND];
    logic [3:0]  keep;

    int cyc = 0;
    int n_vec = 0;
    int n_bad = 0;
    bit done = 1'b0;

    ack_exp_t ack_q[$];
    dat_exp_t dat_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] mem_word(input logic [23:0] m, input int i);
        return (m[15:0] + 16'(i)) ^ {m[23:22], 14'h0A5C};
    endfunction

    function automatic logic [21:0] addr_of(input int b);
        case (b)
            0:       return a0;
            1:       return a1;
            2:       return a2;
            default: return a3;
        endcase
    endfunction

    generate
        for (genvar gi = 0; gi < ND; gi++) begin : g_dut
            localparam int B = (gi == 1) ? 1 : (gi == 2) ? 4 : 2;
            localparam int L = (gi == 1) ? 1 : (gi == 2) ? 7 : 2;
            logic [15:0] mem_din;
            logic        pend;
            int          rdc;
            logic [23:0] rda;

            jtpang_bank_resp #(.BURST(B), .LATENCY(L)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .ba0_addr  (a0),
                .ba1_addr  (a1),
                .ba2_addr  (a2),
                .ba3_addr  (a3),
                .ba_rd     (rd_v[gi]),
                .hold      (hold),
                .ba_ack    (ack_o[gi]),
                .ba_dst    (dst_o[gi]),
                .ba_dok    (dok_o[gi]),
                .ba_rdy    (rdy_o[gi]),
                .data_read (dat_o[gi]),
                .mem_rd    (mrd_o[gi]),
                .mem_addr  (maddr_o[gi]),
                .mem_din   (mem_din)
            );

            // Fixed-latency memory: words valid only on cycles L..L+B-1 after
            // mem_rd, a marker value otherwise.
            initial begin
                pend    = 1'b0;
                rdc     = 0;
                rda     = 24'd0;
                mem_din = 16'hDEAD;
                forever begin
                    @(negedge clk);
                    if (!rst_n) begin
                        pend    = 1'b0;
                        mem_din = 16'hDEAD;
                    end else begin
                        if (mrd_o[gi]) begin
                            pend = 1'b1;
                            rdc  = cyc;
                            rda  = maddr_o[gi];
                        end
                        if (pend && cyc >= rdc + L && cyc <= rdc + L + B - 1)
                            mem_din = mem_word(rda, cyc - rdc - L);
                        else
                            mem_din = 16'hDEAD;
                    end
                end
            end
        end
    endgenerate

    // Monitor / scoreboard
    initial begin
        ack_exp_t ea;
        dat_exp_t ed;
        bit       end_chk;
        end_chk = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                for (int d = 0; d < ND; d++) begin
                    n_vec++;
                    if (ack_o[d] !== 4'd0 || mrd_o[d] !== 1'b0 || dst_o[d] !== 1'b0 ||
                        dok_o[d] !== 1'b0 || rdy_o[d] !== 1'b0 || dat_o[d] !== 16'd0 ||
                        maddr_o[d] !== 24'd0) begin
                        n_bad++;
                        $display("FAIL reset_values dut%0d cyc %0d: ack=%b mem_rd=%b dst=%b dok=%b rdy=%b data=%h mem_addr=%h, required all zero",
                                 d, cyc, ack_o[d], mrd_o[d], dst_o[d], dok_o[d], rdy_o[d], dat_o[d], maddr_o[d]);
                    end
                end
            end else begin
                for (int d = 0; d < ND; d++) begin
                    if (mrd_o[d] && ack_o[d] == 4'd0) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL mem_rd_alone dut%0d cyc %0d: mem_rd=1 with ack=0000, required mem_rd only with ack", d, cyc);
                    end
                    if (ack_o[d] != 4'd0) begin
                        n_vec++;
                        if (ack_q.size() == 0 || ack_q[0].dut != d) begin
                            n_bad++;
                            $display("FAIL unexpected_ack dut%0d cyc %0d: ack=%b mem_addr=%h, required no grant", d, cyc, ack_o[d], maddr_o[d]);
                        end else begin
                            ea = ack_q.pop_front();
                            if (cyc != ea.cyc || ack_o[d] !== ea.ack || maddr_o[d] !== ea.addr ||
                                mrd_o[d] !== 1'b1 || dok_o[d] !== 1'b0) begin
                                n_bad++;
                                $display("FAIL grant dut%0d: got cyc=%0d ack=%b mem_addr=%h mem_rd=%b dok=%b, required cyc=%0d ack=%b mem_addr=%h mem_rd=1 dok=0",
                                         d, cyc, ack_o[d], maddr_o[d], mrd_o[d], dok_o[d], ea.cyc, ea.ack, ea.addr);
                            end
                        end
                    end
                    if (dok_o[d]) begin
                        n_vec++;
                        if (dat_q.size() == 0 || dat_q[0].dut != d) begin
                            n_bad++;
                            $display("FAIL unexpected_dok dut%0d cyc %0d: data=%h dst=%b rdy=%b, required no data", d, cyc, dat_o[d], dst_o[d], rdy_o[d]);
                        end else begin
                            ed = dat_q.pop_front();
                            if (cyc != ed.cyc || dat_o[d] !== ed.data || dst_o[d] !== ed.dst || rdy_o[d] !== ed.rdy) begin
                                n_bad++;
                                $display("FAIL data dut%0d: got cyc=%0d data=%h dst=%b rdy=%b, required cyc=%0d data=%h dst=%b rdy=%b",
                                         d, cyc, dat_o[d], dst_o[d], rdy_o[d], ed.cyc, ed.data, ed.dst, ed.rdy);
                            end
                        end
                    end else if (dst_o[d] || rdy_o[d]) begin
                        n_vec++;
                        n_bad++;
                        $display("FAIL strobe_without_dok dut%0d cyc %0d: dst=%b rdy=%b, required 0 0", d, cyc, dst_o[d], rdy_o[d]);
                    end
                end
            end
            if (done && !end_chk) begin
                end_chk = 1'b1;
                n_vec++;
                if (ack_q.size() != 0 || dat_q.size() != 0) begin
                    n_bad++;
                    $display("FAIL missing_events: %0d grants and %0d words never seen, required 0 and 0", ack_q.size(), dat_q.size());
                end
            end
        end
    end

    // Advance to the next negedge; acked requests drop unless kept high.
    task automatic tick();
        @(negedge clk);
        for (int d = 0; d < ND; d++)
            rd_v[d] = rd_v[d] & ~(ack_o[d] & ~keep);
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic reset_pulse();
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();
    endtask

    task automatic exp_burst(input int d, input int tg, input int bank, input int lat,
                             input int bl, input bit with_data);
        ack_exp_t    ea;
        dat_exp_t    ed;
        logic [23:0] m;
        m       = {2'(bank), addr_of(bank)};
        ea.dut  = d;
        ea.cyc  = tg;
        ea.ack  = 4'(4'b0001 << bank);
        ea.addr = m;
        ack_q.push_back(ea);
        if (with_data) begin
            for (int i = 0; i < bl; i++) begin
                ed.dut  = d;
                ed.cyc  = tg + 1 + lat + i;
                ed.data = mem_word(m, i);
                ed.dst  = (i == 0);
                ed.rdy  = (i == bl - 1);
                dat_q.push_back(ed);
            end
        end
    endtask

    initial begin
        int t;
        rst_n = 1'b1;
        hold  = 1'b0;
        keep  = 4'd0;
        a0 = 22'd0; a1 = 22'd0; a2 = 22'd0; a3 = 22'd0;
        for (int d = 0; d < ND; d++) rd_v[d] = 4'd0;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Single request on bank 2
        t  = cyc;
        a2 = 22'h01234;
        rd_v[0] = 4'b0100;
        exp_burst(0, t + 1, 2, 2, 2, 1);
        wait_until(t + 10);

        // All four at once after reset, two rounds, 6 cycles apart
        reset_pulse();
        t  = cyc;
        a0 = 22'h000010; a1 = 22'h3FFFFF; a2 = 22'h155555; a3 = 22'h0ABCDE;
        rd_v[0] = 4'b1111;
        for (int k = 0; k < 8; k++) exp_burst(0, t + 1 + 6 * k, k % 4, 2, 2, 1);
        wait_until(t + 22);
        rd_v[0] = 4'b1111;
        wait_until(t + 52);

        // Fairness: bank 1 continuous, bank 3 arrives mid-burst
        reset_pulse();
        t    = cyc;
        keep = 4'b0010;
        rd_v[0] = 4'b0010;
        exp_burst(0, t + 1, 1, 2, 2, 1);
        exp_burst(0, t + 7, 3, 2, 2, 1);
        exp_burst(0, t + 13, 1, 2, 2, 1);
        wait_until(t + 3);
        rd_v[0] = rd_v[0] | 4'b1000;
        wait_until(t + 10);
        keep = 4'd0;
        wait_until(t + 22);

        // hold raised during bank-0 DATA, released later
        reset_pulse();
        t = cyc;
        rd_v[0] = 4'b0001;
        exp_burst(0, t + 1, 0, 2, 2, 1);
        wait_until(t + 4);
        hold = 1'b1;
        rd_v[0] = rd_v[0] | 4'b0100;
        wait_until(t + 10);
        hold = 1'b0;
        exp_burst(0, t + 11, 2, 2, 2, 1);
        wait_until(t + 20);

        // BURST=1, LATENCY=1: back-to-back grants 4 cycles apart
        t = cyc;
        rd_v[1] = 4'b1001;
        exp_burst(1, t + 1, 0, 1, 1, 1);
        exp_burst(1, t + 5, 3, 1, 1, 1);
        wait_until(t + 10);

        // BURST=4, LATENCY=7
        t = cyc;
        rd_v[2] = 4'b0010;
        exp_burst(2, t + 1, 1, 7, 4, 1);
        wait_until(t + 16);

        // Reset while waiting for data: burst abandoned, bank 0 wins after
        t = cyc;
        rd_v[0] = 4'b0100;
        exp_burst(0, t + 1, 2, 2, 2, 0);
        wait_until(t + 1);
        reset_pulse();
        t = cyc;
        rd_v[0] = 4'b0101;
        exp_burst(0, t + 1, 0, 2, 2, 1);
        exp_burst(0, t + 7, 2, 2, 2, 1);
        wait_until(t + 16);

        done = 1'b1;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
